// File: rtl/gate_sweep_if.sv
// gate_sweep_if: handshake, gate drive and result bundle between gate_sweep_checker and its user
interface gate_sweep_if #(parameter int N_IN = 1);
  logic            start;
  logic            gate_out;
  logic [N_IN-1:0] gate_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_idx;
  logic            fail_valid;
  modport master (input start, gate_out, output gate_in, busy, done, pass, err_count, fail_idx, fail_valid);
  modport slave (output start, gate_out, input gate_in, busy, done, pass, err_count, fail_idx, fail_valid);
endinterface

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: truth-table sweep of a gate under test; GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep on the first mismatch
module gate_sweep_checker #(
  parameter int N_IN = 1,
  parameter int SETTLE_CYC = 2,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = 2'b01
) (
  input logic clk,
  input logic rst_n,
  gate_sweep_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [N_IN-1:0] pat;
  logic [3:0] cnt;
  logic mis, fin;
  logic [N_IN:0] err_nxt;
  // compare of the current pattern and the sweep-termination decision
  always_comb begin
    mis = bus.gate_out != EXP_TT[pat];
    err_nxt = bus.err_count + {{N_IN{1'b0}}, mis};
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    fin = (&pat) || mis;
`else
    fin = &pat;
`endif
  end
  // sweep sequencer: hold each pattern SETTLE_CYC+1 cycles, sample on the last one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pat <= '0;
      cnt <= '0;
      bus.gate_in <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.err_count <= '0;
      bus.fail_idx <= '0;
      bus.fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.gate_in <= '0;
          if (bus.start) begin
            state <= RUN;
            pat <= '0;
            cnt <= '0;
            bus.busy <= 1'b1;
            bus.pass <= 1'b0;
            bus.err_count <= '0;
            bus.fail_idx <= '0;
            bus.fail_valid <= 1'b0;
          end
        end
        RUN: begin
          if (cnt != 4'(SETTLE_CYC)) begin
            cnt <= cnt + 4'd1;
          end else begin
            bus.err_count <= err_nxt;
            if (mis && !bus.fail_valid) begin
              bus.fail_idx <= pat;
              bus.fail_valid <= 1'b1;
            end
            if (fin) begin
              state <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= err_nxt == '0;
              bus.gate_in <= '0;
            end else begin
              pat <= pat + 1'b1;
              bus.gate_in <= pat + 1'b1;
              cnt <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: scoreboard bench over a NOT, a stuck AND and a faulty XOR gate
module tb_gate_sweep_checker;
  typedef struct {int lat; logic pass; int err; int fidx; logic fval;} res_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n0, rst_n1, rst_n2, good0;
  int sel, n_vec, n_bad;
  int trace[$];
  res_t sb[$];
  gate_sweep_if #(.N_IN(1)) b0();
  gate_sweep_if #(.N_IN(2)) b1();
  gate_sweep_if #(.N_IN(2)) b2();
  gate_sweep_checker #(.N_IN(1), .SETTLE_CYC(2), .EXP_TT(2'b01)) u0 (.clk(clk), .rst_n(rst_n0), .bus(b0));
  gate_sweep_checker #(.N_IN(2), .SETTLE_CYC(0), .EXP_TT(4'b1000)) u1 (.clk(clk), .rst_n(rst_n1), .bus(b1));
  gate_sweep_checker #(.N_IN(2), .SETTLE_CYC(1), .EXP_TT(4'b0110)) u2 (.clk(clk), .rst_n(rst_n2), .bus(b2));
  assign b0.gate_out = good0 ? ~b0.gate_in[0] : 1'b0;
  assign b1.gate_out = 1'b1;
  assign b2.gate_out = (b2.gate_in == 2'd3) ? 1'b1 : ^b2.gate_in;
  logic [3:0] gin_s, err_s, fidx_s;
  logic done_s, busy_s, pass_s, fval_s;
  assign gin_s = sel == 0 ? 4'(b0.gate_in) : sel == 1 ? 4'(b1.gate_in) : 4'(b2.gate_in);
  assign err_s = sel == 0 ? 4'(b0.err_count) : sel == 1 ? 4'(b1.err_count) : 4'(b2.err_count);
  assign fidx_s = sel == 0 ? 4'(b0.fail_idx) : sel == 1 ? 4'(b1.fail_idx) : 4'(b2.fail_idx);
  assign done_s = sel == 0 ? b0.done : sel == 1 ? b1.done : b2.done;
  assign busy_s = sel == 0 ? b0.busy : sel == 1 ? b1.busy : b2.busy;
  assign pass_s = sel == 0 ? b0.pass : sel == 1 ? b1.pass : b2.pass;
  assign fval_s = sel == 0 ? b0.fail_valid : sel == 1 ? b1.fail_valid : b2.fail_valid;

  function automatic int settle_of(int s);
    return s == 0 ? 2 : s == 1 ? 0 : 1;
  endfunction

  function automatic logic gate_fn(int s, int i);
    logic [3:0] v;
    v = 4'(i);
    if (s == 0) return good0 ? ~v[0] : 1'b0;
    if (s == 1) return 1'b1;
    return v == 4'd3 ? 1'b1 : v[0] ^ v[1];
  endfunction

  function automatic res_t model(int s);
    res_t r;
    logic [3:0] tt;
    int p, st;
    tt = s == 0 ? 4'b0001 : s == 1 ? 4'b1000 : 4'b0110;
    p = s == 0 ? 2 : 4;
    st = settle_of(s);
    r.lat = p * (st + 1);
    r.err = 0;
    r.fidx = 0;
    r.fval = 1'b0;
    for (int i = 0; i < p; i++) begin
      if (gate_fn(s, i) !== tt[i]) begin
        if (!r.fval) begin
          r.fidx = i;
          r.fval = 1'b1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
          r.lat = (i + 1) * (st + 1);
`endif
        end
        r.err++;
      end
    end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    if (r.err > 1) r.err = 1;
`endif
    r.pass = r.err == 0;
    return r;
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s == 0) b0.start = v;
    else if (s == 1) b1.start = v;
    else b2.start = v;
  endtask

  task automatic run_sweep(input int s, input bit repulse, output int lat);
    sel = s;
    repeat (2) @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk);
    #1;
    set_start(s, 1'b0);
    trace.delete();
    trace.push_back(int'(gin_s));
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (repulse) set_start(s, (k - 1) == 2 || (k - 1) == 4);
      @(posedge clk);
      #1;
      if (done_s) begin
        lat = k;
        break;
      end
      trace.push_back(int'(gin_s));
    end
    set_start(s, 1'b0);
  endtask

  task automatic test_reset;
    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    sel = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (gin_s !== 4'd0) begin n_bad++; $display("FAIL reset gate_in got %0d want 0", gin_s); end
    n_vec++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL reset busy got %0b want 0", busy_s); end
    n_vec++; if (done_s !== 1'b0) begin n_bad++; $display("FAIL reset done got %0b want 0", done_s); end
    n_vec++; if (pass_s !== 1'b0) begin n_bad++; $display("FAIL reset pass got %0b want 0", pass_s); end
    n_vec++; if (err_s !== 4'd0) begin n_bad++; $display("FAIL reset err_count got %0d want 0", err_s); end
    n_vec++; if (fidx_s !== 4'd0) begin n_bad++; $display("FAIL reset fail_idx got %0d want 0", fidx_s); end
    n_vec++; if (fval_s !== 1'b0) begin n_bad++; $display("FAIL reset fail_valid got %0b want 0", fval_s); end
    @(negedge clk);
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
  endtask

  task automatic test_sweep(input string name, input int s, input bit repulse);
    int lat, st;
    bit ok;
    res_t e;
    st = settle_of(s);
    sb.push_back(model(s));
    run_sweep(s, repulse, lat);
    e = sb.pop_front();
    n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL %s latency got %0d want %0d", name, lat, e.lat); end
    n_vec++; if (pass_s !== e.pass) begin n_bad++; $display("FAIL %s pass got %0b want %0b", name, pass_s, e.pass); end
    n_vec++; if (err_s !== 4'(e.err)) begin n_bad++; $display("FAIL %s err_count got %0d want %0d", name, err_s, e.err); end
    n_vec++; if (fidx_s !== 4'(e.fidx)) begin n_bad++; $display("FAIL %s fail_idx got %0d want %0d", name, fidx_s, e.fidx); end
    n_vec++; if (fval_s !== e.fval) begin n_bad++; $display("FAIL %s fail_valid got %0b want %0b", name, fval_s, e.fval); end
    ok = trace.size() == lat;
    foreach (trace[c]) if (trace[c] != c / (st + 1)) ok = 1'b0;
    n_vec++; if (!ok) begin n_bad++; $display("FAIL %s gate_in sequence got %0d cycles (first %0d) want %0d cycles", name, trace.size(), trace.size() > 0 ? trace[0] : -1, lat); end
    @(posedge clk);
    #1;
    n_vec++; if (done_s !== 1'b0 || busy_s !== 1'b0) begin n_bad++; $display("FAIL %s after-done done=%0b busy=%0b want 0 0", name, done_s, busy_s); end
    n_vec++; if (err_s !== 4'(e.err)) begin n_bad++; $display("FAIL %s held err_count got %0d want %0d", name, err_s, e.err); end
  endtask

  task automatic test_reset_mid_sweep;
    int dones;
    good0 = 1'b0;
    sel = 0;
    repeat (2) @(negedge clk);
    b0.start = 1'b1;
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (err_s !== 4'd1) begin n_bad++; $display("FAIL midreset pre err_count got %0d want 1", err_s); end
    rst_n0 = 1'b0;
    @(posedge clk);
    #1;
    rst_n0 = 1'b1;
    n_vec++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL midreset busy got %0b want 0", busy_s); end
    n_vec++; if (gin_s !== 4'd0) begin n_bad++; $display("FAIL midreset gate_in got %0d want 0", gin_s); end
    n_vec++; if (err_s !== 4'd0) begin n_bad++; $display("FAIL midreset err_count got %0d want 0", err_s); end
    n_vec++; if (fval_s !== 1'b0) begin n_bad++; $display("FAIL midreset fail_valid got %0b want 0", fval_s); end
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      if (done_s) dones++;
      @(posedge clk);
      #1;
    end
    n_vec++; if (dones != 0) begin n_bad++; $display("FAIL midreset done pulses got %0d want 0", dones); end
    good0 = 1'b1;
    test_sweep("after_reset", 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int lat;
    res_t e;
    good0 = 1'b1;
    sel = 0;
    sb.push_back(model(0));
    sb.push_back(model(0));
    repeat (2) @(negedge clk);
    b0.start = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
        @(posedge clk);
        #1;
        if (done_s) begin
          lat = k;
          break;
        end
      end
      e = sb.pop_front();
      n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL b2b%0d latency got %0d want %0d", r, lat, e.lat); end
      n_vec++; if (pass_s !== e.pass) begin n_bad++; $display("FAIL b2b%0d pass got %0b want %0b", r, pass_s, e.pass); end
      @(posedge clk);
      #1;
      n_vec++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin n_bad++; $display("FAIL b2b%0d idle gap busy=%0b done=%0b want 0 0", r, busy_s, done_s); end
      if (r == 1) b0.start = 1'b0;
    end
    @(posedge clk);
    #1;
    n_vec++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL b2b released busy got %0b want 0", busy_s); end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    good0 = 1'b1;
    sel = 0;
    b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0;
    test_reset;
    test_sweep("good_not", 0, 1'b0);
    good0 = 1'b0;
    test_sweep("bad_not", 0, 1'b0);
    good0 = 1'b1;
    test_sweep("and_stuck", 1, 1'b0);
    test_sweep("xor_fault", 2, 1'b0);
    test_sweep("start_ignored", 0, 1'b1);
    test_reset_mid_sweep;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
